// File: rtl/lsu_wb_unit.sv
// LSU/writeback stage: one data-memory access per instruction over a req/ack bus, then a one-cycle retire pulse.
// Optional macro LSU_TIMEOUT_EN aborts an access that sees no ack within TIMEOUT_CYCLES.
module lsu_wb_unit
`ifdef LSU_TIMEOUT_EN
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
)
`endif
(
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        mem_ren,
    input  logic        mem_wen,
    input  logic        R_wen,
    input  logic [3:0]  csr_wen,
    input  logic [31:0] Ex_result,
    input  logic [4:0]  rd,
    input  logic [2:0]  funct3,
    input  logic [31:0] rs2_value,
    input  logic        jump_flag,
    input  logic [31:0] rd_value,
    input  logic [31:0] pc,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        wb_valid,
    output logic        wb_wen,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic [31:0] wb_pc,
    output logic [3:0]  csr_wen_o,
    output logic [31:0] csr_wdata,
    output logic        lsu_err
);
    typedef enum logic [0:0] {IDLE = 1'b0, BUS = 1'b1} state_t;
    state_t state;

    logic        accept;
    logic        is_store;
    logic        is_mem;
    logic        illegal;
    logic        misaligned;
    logic [3:0]  st_strb;
    logic [31:0] st_wdata;
    logic [31:0] alt_data;
    logic [31:0] ld_data;
    logic [31:0] ld_shift;

    // Payload held for the duration of a bus access
    logic        p_load;
    logic [2:0]  p_f3;
    logic [1:0]  p_off;
    logic        p_wen;
    logic [4:0]  p_rd;
    logic [3:0]  p_csr;
    logic [31:0] p_csr_wdata;
    logic [31:0] p_alt;
    logic [31:0] p_pc;

`ifdef LSU_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [CNT_W-1:0] tmo_cnt;
`endif

    assign in_ready = (state == IDLE) && reset;
    assign accept   = in_valid && in_ready;
    assign is_store = mem_wen;
    assign is_mem   = mem_wen || mem_ren;
    assign alt_data = jump_flag ? rd_value : Ex_result;

    always_comb begin
        illegal = is_store ? (funct3 >= 3'd3) : ((funct3 == 3'd3) || (funct3[2:1] == 2'b11));
        misaligned = ((funct3[1:0] == 2'b01) && Ex_result[0])
                  || ((funct3[1:0] == 2'b10) && (Ex_result[1:0] != 2'b00));
    end

    // Store data is replicated across lanes; strobes select the addressed bytes
    always_comb begin
        st_wdata = rs2_value;
        st_strb  = 4'b1111;
        case (funct3[1:0])
            2'b00: begin
                st_wdata = {4{rs2_value[7:0]}};
                st_strb  = 4'(4'b0001 << Ex_result[1:0]);
            end
            2'b01: begin
                st_wdata = {2{rs2_value[15:0]}};
                st_strb  = 4'(4'b0011 << Ex_result[1:0]);
            end
            default: begin
                st_wdata = rs2_value;
                st_strb  = 4'b1111;
            end
        endcase
    end

    always_comb begin
        ld_shift = mem_rdata >> {p_off, 3'b000};
        case (p_f3)
            3'b000:  ld_data = {{24{ld_shift[7]}}, ld_shift[7:0]};
            3'b001:  ld_data = p_off[1] ? {{16{mem_rdata[31]}}, mem_rdata[31:16]}
                                        : {{16{mem_rdata[15]}}, mem_rdata[15:0]};
            3'b100:  ld_data = {24'd0, ld_shift[7:0]};
            3'b101:  ld_data = p_off[1] ? {16'd0, mem_rdata[31:16]} : {16'd0, mem_rdata[15:0]};
            default: ld_data = mem_rdata;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state       <= IDLE;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= 32'd0;
            mem_wdata   <= 32'd0;
            mem_wstrb   <= 4'd0;
            wb_valid    <= 1'b0;
            wb_wen      <= 1'b0;
            wb_rd       <= 5'd0;
            wb_data     <= 32'd0;
            wb_pc       <= 32'd0;
            csr_wen_o   <= 4'd0;
            csr_wdata   <= 32'd0;
            lsu_err     <= 1'b0;
            p_load      <= 1'b0;
            p_f3        <= 3'd0;
            p_off       <= 2'd0;
            p_wen       <= 1'b0;
            p_rd        <= 5'd0;
            p_csr       <= 4'd0;
            p_csr_wdata <= 32'd0;
            p_alt       <= 32'd0;
            p_pc        <= 32'd0;
`ifdef LSU_TIMEOUT_EN
            tmo_cnt     <= '0;
`endif
        end else begin
            wb_valid  <= 1'b0;
            lsu_err   <= 1'b0;
            csr_wen_o <= 4'd0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (!is_mem) begin
                            wb_valid  <= 1'b1;
                            wb_wen    <= R_wen && (rd != 5'd0);
                            wb_rd     <= rd;
                            wb_data   <= alt_data;
                            wb_pc     <= pc;
                            csr_wen_o <= csr_wen;
                            csr_wdata <= Ex_result;
                        end else if (illegal || misaligned) begin
                            lsu_err <= 1'b1;
                        end else begin
                            state       <= BUS;
                            mem_req     <= 1'b1;
                            mem_we      <= is_store;
                            mem_addr    <= {Ex_result[31:2], 2'b00};
                            mem_wdata   <= is_store ? st_wdata : 32'd0;
                            mem_wstrb   <= is_store ? st_strb : 4'd0;
                            p_load      <= !is_store;
                            p_f3        <= funct3;
                            p_off       <= Ex_result[1:0];
                            p_wen       <= R_wen && (rd != 5'd0) && !is_store;
                            p_rd        <= rd;
                            p_csr       <= csr_wen;
                            p_csr_wdata <= Ex_result;
                            p_alt       <= alt_data;
                            p_pc        <= pc;
`ifdef LSU_TIMEOUT_EN
                            tmo_cnt     <= '0;
`endif
                        end
                    end
                end
                BUS: begin
                    if (mem_ack) begin
                        state     <= IDLE;
                        mem_req   <= 1'b0;
                        wb_valid  <= 1'b1;
                        wb_wen    <= p_wen;
                        wb_rd     <= p_rd;
                        wb_data   <= p_load ? ld_data : p_alt;
                        wb_pc     <= p_pc;
                        csr_wen_o <= p_csr;
                        csr_wdata <= p_csr_wdata;
                    end
`ifdef LSU_TIMEOUT_EN
                    else if (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        state   <= IDLE;
                        mem_req <= 1'b0;
                        lsu_err <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + CNT_W'(1);
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lsu_wb_unit.sv
// Directed bench for lsu_wb_unit; define LSU_TIMEOUT_EN to exercise the ack timeout with TIMEOUT_CYCLES=4.
module tb_lsu_wb_unit;
    logic        clock;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic        mem_ren;
    logic        mem_wen;
    logic        R_wen;
    logic [3:0]  csr_wen;
    logic [31:0] Ex_result;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [31:0] rs2_value;
    logic        jump_flag;
    logic [31:0] rd_value;
    logic [31:0] pc;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        wb_valid;
    logic        wb_wen;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [31:0] wb_pc;
    logic [3:0]  csr_wen_o;
    logic [31:0] csr_wdata;
    logic        lsu_err;

    int checks;
    int failures;

`ifdef LSU_TIMEOUT_EN
    lsu_wb_unit #(.TIMEOUT_CYCLES(4)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .mem_ren(mem_ren), .mem_wen(mem_wen), .R_wen(R_wen), .csr_wen(csr_wen),
        .Ex_result(Ex_result), .rd(rd), .funct3(funct3), .rs2_value(rs2_value),
        .jump_flag(jump_flag), .rd_value(rd_value), .pc(pc),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .wb_valid(wb_valid), .wb_wen(wb_wen), .wb_rd(wb_rd), .wb_data(wb_data),
        .wb_pc(wb_pc), .csr_wen_o(csr_wen_o), .csr_wdata(csr_wdata), .lsu_err(lsu_err)
    );
`else
    lsu_wb_unit dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .mem_ren(mem_ren), .mem_wen(mem_wen), .R_wen(R_wen), .csr_wen(csr_wen),
        .Ex_result(Ex_result), .rd(rd), .funct3(funct3), .rs2_value(rs2_value),
        .jump_flag(jump_flag), .rd_value(rd_value), .pc(pc),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .wb_valid(wb_valid), .wb_wen(wb_wen), .wb_rd(wb_rd), .wb_data(wb_data),
        .wb_pc(wb_pc), .csr_wen_o(csr_wen_o), .csr_wdata(csr_wdata), .lsu_err(lsu_err)
    );
`endif

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic clear_in();
        in_valid  = 1'b0;
        mem_ren   = 1'b0;
        mem_wen   = 1'b0;
        R_wen     = 1'b0;
        csr_wen   = 4'd0;
        Ex_result = 32'd0;
        rd        = 5'd0;
        funct3    = 3'd0;
        rs2_value = 32'd0;
        jump_flag = 1'b0;
        rd_value  = 32'd0;
        pc        = 32'd0;
    endtask

    // Present one memory instruction for a single accept cycle
    task automatic issue_mem(input logic ld, input logic st, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] sdata,
                             input logic [4:0] dst, input logic [31:0] ipc);
        clear_in();
        in_valid  = 1'b1;
        mem_ren   = ld;
        mem_wen   = st;
        funct3    = f3;
        Ex_result = addr;
        rs2_value = sdata;
        rd        = dst;
        R_wen     = 1'b1;
        pc        = ipc;
        tick();
        clear_in();
    endtask

    task automatic ack_with(input logic [31:0] data);
        mem_ack   = 1'b1;
        mem_rdata = data;
        tick();
        mem_ack   = 1'b0;
        mem_rdata = 32'd0;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        clear_in();
        mem_ack   = 1'b0;
        mem_rdata = 32'd0;
        reset     = 1'b0;
        tick();
        tick();
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_lsu_err", 32'(lsu_err), 32'd0);
        reset = 1'b1;
        tick();
        chk("rel_in_ready", 32'(in_ready), 32'd1);

        // Back-to-back ALU retires
        for (int i = 0; i < 3; i++) begin
            in_valid  = 1'b1;
            Ex_result = 32'h1234;
            R_wen     = 1'b1;
            rd        = 5'd5;
            pc        = 32'h100 + 32'(i * 4);
            tick();
            chk("alu_wb_valid", 32'(wb_valid), 32'd1);
            chk("alu_wb_data", wb_data, 32'h1234);
            chk("alu_wb_wen", 32'(wb_wen), 32'd1);
            chk("alu_wb_pc", wb_pc, 32'h100 + 32'(i * 4));
            chk("alu_in_ready", 32'(in_ready), 32'd1);
        end
        clear_in();
        tick();
        chk("alu_idle_wb_valid", 32'(wb_valid), 32'd0);
        chk("alu_hold_wb_data", wb_data, 32'h1234);

        // SB to byte 3, ack after two request cycles
        issue_mem(1'b0, 1'b1, 3'b000, 32'h1003, 32'hAB, 5'd3, 32'h200);
        chk("sb_req", 32'(mem_req), 32'd1);
        chk("sb_we", 32'(mem_we), 32'd1);
        chk("sb_addr", mem_addr, 32'h1000);
        chk("sb_wdata", mem_wdata, 32'hABABABAB);
        chk("sb_wstrb", 32'(mem_wstrb), 32'h8);
        chk("sb_in_ready", 32'(in_ready), 32'd0);
        chk("sb_wb_valid_wait", 32'(wb_valid), 32'd0);
        tick();
        chk("sb_req_hold", 32'(mem_req), 32'd1);
        chk("sb_wstrb_hold", 32'(mem_wstrb), 32'h8);
        ack_with(32'd0);
        chk("sb_req_drop", 32'(mem_req), 32'd0);
        chk("sb_wb_valid", 32'(wb_valid), 32'd1);
        chk("sb_wb_wen", 32'(wb_wen), 32'd0);
        chk("sb_wb_pc", wb_pc, 32'h200);
        chk("sb_in_ready_after", 32'(in_ready), 32'd1);
        tick();
        chk("sb_wb_valid_pulse", 32'(wb_valid), 32'd0);

        // SH upper half
        issue_mem(1'b0, 1'b1, 3'b001, 32'h2002, 32'h1234ABCD, 5'd0, 32'h204);
        chk("sh_wdata", mem_wdata, 32'hABCDABCD);
        chk("sh_wstrb", 32'(mem_wstrb), 32'hC);
        ack_with(32'd0);
        chk("sh_wb_valid", 32'(wb_valid), 32'd1);

        // LB with same-cycle ack
        issue_mem(1'b1, 1'b0, 3'b000, 32'h2001, 32'd0, 5'd7, 32'h300);
        chk("lb_req", 32'(mem_req), 32'd1);
        chk("lb_we", 32'(mem_we), 32'd0);
        chk("lb_wstrb", 32'(mem_wstrb), 32'd0);
        chk("lb_addr", mem_addr, 32'h2000);
        ack_with(32'h0000_8000);
        chk("lb_wb_valid", 32'(wb_valid), 32'd1);
        chk("lb_wb_data", wb_data, 32'hFFFFFF80);
        chk("lb_wb_wen", 32'(wb_wen), 32'd1);
        chk("lb_wb_rd", 32'(wb_rd), 32'd7);

        // LBU with one wait cycle
        issue_mem(1'b1, 1'b0, 3'b100, 32'h2001, 32'd0, 5'd7, 32'h304);
        tick();
        chk("lbu_wb_valid_wait", 32'(wb_valid), 32'd0);
        ack_with(32'h0000_8000);
        chk("lbu_wb_data", wb_data, 32'h00000080);

        // LH / LHU upper half, LW
        issue_mem(1'b1, 1'b0, 3'b001, 32'h2002, 32'd0, 5'd8, 32'h308);
        ack_with(32'h8001_0000);
        chk("lh_wb_data", wb_data, 32'hFFFF8001);
        issue_mem(1'b1, 1'b0, 3'b101, 32'h2002, 32'd0, 5'd8, 32'h30C);
        ack_with(32'h8001_0000);
        chk("lhu_wb_data", wb_data, 32'h00008001);
        issue_mem(1'b1, 1'b0, 3'b010, 32'h2004, 32'd0, 5'd9, 32'h310);
        ack_with(32'hDEADBEEF);
        chk("lw_wb_data", wb_data, 32'hDEADBEEF);

        // Both enables set behaves as a store
        issue_mem(1'b1, 1'b1, 3'b010, 32'h6000, 32'h11223344, 5'd4, 32'h314);
        chk("ldst_we", 32'(mem_we), 32'd1);
        chk("ldst_wstrb", 32'(mem_wstrb), 32'hF);
        chk("ldst_wdata", mem_wdata, 32'h11223344);
        ack_with(32'hFFFFFFFF);
        chk("ldst_wb_wen", 32'(wb_wen), 32'd0);

        // Misaligned and illegal accesses
        issue_mem(1'b1, 1'b0, 3'b010, 32'h3002, 32'd0, 5'd6, 32'h400);
        chk("mis_lsu_err", 32'(lsu_err), 32'd1);
        chk("mis_mem_req", 32'(mem_req), 32'd0);
        chk("mis_wb_valid", 32'(wb_valid), 32'd0);
        chk("mis_in_ready", 32'(in_ready), 32'd1);
        tick();
        chk("mis_err_pulse", 32'(lsu_err), 32'd0);
        chk("mis_mem_req_after", 32'(mem_req), 32'd0);
        issue_mem(1'b1, 1'b0, 3'b011, 32'h3000, 32'd0, 5'd6, 32'h404);
        chk("ill_ld_err", 32'(lsu_err), 32'd1);
        chk("ill_ld_req", 32'(mem_req), 32'd0);
        issue_mem(1'b0, 1'b1, 3'b100, 32'h3000, 32'd0, 5'd6, 32'h408);
        chk("ill_st_err", 32'(lsu_err), 32'd1);
        issue_mem(1'b0, 1'b1, 3'b001, 32'h3001, 32'd0, 5'd6, 32'h40C);
        chk("mis_sh_err", 32'(lsu_err), 32'd1);
        chk("mis_sh_wb_valid", 32'(wb_valid), 32'd0);

        // Jump with rd=0 and CSR write
        clear_in();
        in_valid  = 1'b1;
        jump_flag = 1'b1;
        rd_value  = 32'h104;
        Ex_result = 32'h5555;
        R_wen     = 1'b1;
        rd        = 5'd0;
        csr_wen   = 4'b0011;
        pc        = 32'h500;
        tick();
        clear_in();
        chk("jmp_wb_valid", 32'(wb_valid), 32'd1);
        chk("jmp_wb_wen", 32'(wb_wen), 32'd0);
        chk("jmp_wb_data", wb_data, 32'h104);
        chk("jmp_csr_wen", 32'(csr_wen_o), 32'h3);
        chk("jmp_csr_wdata", csr_wdata, 32'h5555);
        tick();
        chk("jmp_csr_wen_clr", 32'(csr_wen_o), 32'd0);

        // Reset in the middle of a bus access
        issue_mem(1'b1, 1'b0, 3'b010, 32'h4000, 32'd0, 5'd10, 32'h600);
        chk("rbus_req", 32'(mem_req), 32'd1);
        reset = 1'b0;
        tick();
        chk("rbus_req_drop", 32'(mem_req), 32'd0);
        chk("rbus_wb_valid", 32'(wb_valid), 32'd0);
        chk("rbus_lsu_err", 32'(lsu_err), 32'd0);
        reset = 1'b1;
        tick();
        chk("rbus_after_wb_valid", 32'(wb_valid), 32'd0);
        chk("rbus_after_in_ready", 32'(in_ready), 32'd1);
        chk("rbus_after_wb_data", wb_data, 32'd0);

        // No-ack behaviour
        issue_mem(1'b1, 1'b0, 3'b010, 32'h5000, 32'd0, 5'd11, 32'h700);
        chk("tmo_req_c1", 32'(mem_req), 32'd1);
        repeat (3) tick();
        chk("tmo_req_c4", 32'(mem_req), 32'd1);
        chk("tmo_err_c4", 32'(lsu_err), 32'd0);
        tick();
`ifdef LSU_TIMEOUT_EN
        chk("tmo_req_drop", 32'(mem_req), 32'd0);
        chk("tmo_lsu_err", 32'(lsu_err), 32'd1);
        chk("tmo_wb_valid", 32'(wb_valid), 32'd0);
        chk("tmo_in_ready", 32'(in_ready), 32'd1);
        ack_with(32'h12345678);
        chk("tmo_late_ack_wb", 32'(wb_valid), 32'd0);
        chk("tmo_late_ack_err", 32'(lsu_err), 32'd0);
        chk("tmo_late_ack_req", 32'(mem_req), 32'd0);
`else
        repeat (6) tick();
        chk("wait_req_hold", 32'(mem_req), 32'd1);
        chk("wait_in_ready", 32'(in_ready), 32'd0);
        ack_with(32'h12345678);
        chk("wait_wb_valid", 32'(wb_valid), 32'd1);
        chk("wait_wb_data", wb_data, 32'h12345678);
`endif
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/lsu_wb_unit.md
Name: lsu_wb_unit

Overview:
- Consumer end of the EX→LSU/WB pipeline register. Accepts one executed instruction per handshake.
- Performs at most one data-memory access over a req/ack bus: store byte-lane alignment, load extraction and extension.
- Produces a one-cycle register-file/CSR writeback pulse.
- Back-pressures the pipeline register through `in_ready` while a memory access is outstanding.

Parameters:
- TIMEOUT_CYCLES, 255, ack-wait limit in cycles; used only with LSU_TIMEOUT_EN.

Ports:
- clock in 1 rising-edge clock
- reset in 1 synchronous, active-low reset
- in_valid in 1 payload valid from pipeline register
- in_ready out 1 unit can accept payload this cycle
- mem_ren in 1 load instruction
- mem_wen in 1 store instruction
- R_wen in 1 GPR write enable
- csr_wen in 4 CSR write enables
- Ex_result in 32 ALU result / memory address / CSR write data
- rd in 5 destination register
- funct3 in 3 access size/sign
- rs2_value in 32 store data
- jump_flag in 1 jump; writeback uses rd_value
- rd_value in 32 link/CSR-read value
- pc in 32 instruction PC
- mem_req out 1 bus request, held until ack
- mem_we out 1 1 = write
- mem_addr out 32 word-aligned address ({Ex_result[31:2],2'b00})
- mem_wdata out 32 lane-replicated store data
- mem_wstrb out 4 byte strobes (0 for reads)
- mem_ack in 1 access complete; mem_rdata valid this cycle
- mem_rdata in 32 read data
- wb_valid out 1 one-cycle retire pulse
- wb_wen out 1 GPR write (R_wen && rd!=0)
- wb_rd out 5 destination
- wb_data out 32 writeback value
- wb_pc out 32 retired PC
- csr_wen_o out 4 CSR write enables, qualified by wb_valid
- csr_wdata out 32 CSR write data (Ex_result)
- lsu_err out 1 one-cycle pulse: misaligned or illegal access, no writeback

Behaviour:
- Reset (reset==0 at edge): state=IDLE. All outputs 0 except in_ready. in_ready is combinational (state==IDLE) and reads 1 only after reset releases. Reset during BUS drops mem_req at that edge; no writeback, no error.
- States: IDLE, BUS.
- Accept condition: in_valid && in_ready. The payload is latched internally.
- IDLE, accept, no memory op: next cycle wb_valid=1 (latency 1). Stay IDLE, so back-to-back accepts run at 1/cycle.
- IDLE, accept, mem_wen or mem_ren: check access legality.
  - Illegal funct3 for load: 011, 110, 111. Illegal for store: 011 and up.
  - Misaligned: half access with addr[0]=1; word access with addr[1:0]!=0.
  - Illegal or misaligned: next cycle lsu_err=1, wb_valid=0, no bus access, stay IDLE.
  - Otherwise go to BUS. mem_req rises the cycle after accept.
- mem_wen && mem_ren both set: treat as store.
- BUS: mem_req, mem_we, mem_addr, mem_wdata and mem_wstrb are stable until mem_ack. Ack may come in the first request cycle. On ack: mem_req=0 next cycle, wb_valid=1 next cycle, state→IDLE. in_ready=0 throughout BUS.
- Store lanes (a = addr[1:0]):
  - SB: wdata={4{rs2[7:0]}}, wstrb=0001<<a.
  - SH: wdata={2{rs2[15:0]}}, wstrb=0011<<a.
  - SW: wdata=rs2, wstrb=1111.
- Load extraction: LB/LBU take byte a, sign/zero-extended. LH/LHU take half addr[1], sign/zero-extended. LW takes the full word. Read data is captured on the ack cycle.
- wb_data priority: load data, then rd_value if jump_flag, then Ex_result.
- Stores: wb_wen=0; wb_valid still pulses.
- wb_wen = R_wen && rd!=0. csr_wen_o = csr_wen during the wb_valid pulse, else 0.
- wb_* outputs are registered and hold their last value when wb_valid=0.

Optional Feature:
- Macro LSU_TIMEOUT_EN.
- Defined: a counter starts at 0 on BUS entry and increments each BUS cycle without ack. When the count reaches TIMEOUT_CYCLES without ack:
  - mem_req drops next cycle.
  - lsu_err pulses.
  - No writeback; state→IDLE.
  - A late ack after abort is ignored.
- Undefined: no counter; BUS waits indefinitely.

Test Plan:
- ALU op, Ex_result=0x1234, R_wen=1, rd=5, back-to-back 3 accepts → wb_valid on each following cycle, wb_data=0x1234, wb_wen=1, in_ready stays 1.
- SB rs2=0xAB, addr=0x1003, ack after 2 cycles → mem_addr=0x1000, wdata=0xABABABAB, wstrb=1000, mem_we=1. in_ready=0 during wait; wb_valid 1 cycle after ack; wb_wen=0.
- LB addr=0x2001, rdata=0x0000_8000 (byte1=0x80), rd=7 → wb_data=0xFFFFFF80. LBU same access → wb_data=0x00000080. Same-cycle ack also passes.
- LW addr=0x3002 → lsu_err pulse next cycle, mem_req never asserted, wb_valid=0. Same for a load with funct3=011.
- Jump, jump_flag=1, rd_value=0x104, rd=0 → wb_valid=1, wb_wen=0. Reset driven low mid-BUS → mem_req=0 next cycle, no wb_valid.
- LSU_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack → lsu_err after 4 BUS cycles, return to IDLE. Ack in the following cycle is ignored.
